// File: rtl/limp_actuator.sv
// limp_actuator: dosing / drain valve sequencer.
// Six-state Moore FSM driven by an upstream mode code, with an 8-bit
// down-timer for dose and drain duration and a one-cycle done pulse.
// Optional completed-operation counter is built only when the macro
// LIMP_ACT_COUNT_EN is defined; otherwise run_count is tied to zero.
module limp_actuator #(
    parameter int unsigned DOSE_CYCLES  = 8,
    parameter int unsigned DRAIN_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       tank_empty,
    output logic       dose_valve,
    output logic       drain_valve,
    output logic       pump,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [7:0] run_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DOSE,
        S_DOSE_HOLD,
        S_DRAIN,
        S_DRAIN_HOLD,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        M_IDLE    = 2'b00,
        M_DOSE    = 2'b01,
        M_CLEAN   = 2'b10,
        M_INVALID = 2'b11
    } mode_t;

    localparam logic [7:0] DOSE_LOAD  = 8'(DOSE_CYCLES - 1);
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       done_q,  done_d;
    mode_t      mode_c;

    assign mode_c = mode_t'(mode);

    // State, timer and done-pulse registers; reset forces IDLE and closes valves at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            done_q  <= done_d;
        end
    end

    // Next-state and timer logic; mode changes are decoded before expiry or tank_empty.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                case (mode_c)
                    M_DOSE:    begin state_d = S_DOSE;  timer_d = DOSE_LOAD;  end
                    M_CLEAN:   begin state_d = S_DRAIN; timer_d = DRAIN_LOAD; end
                    M_INVALID: state_d = S_FAULT;
                    default:   state_d = S_IDLE;
                endcase
            end
            S_DOSE: begin
                case (mode_c)
                    M_IDLE:    state_d = S_IDLE;
                    M_CLEAN:   begin state_d = S_DRAIN; timer_d = DRAIN_LOAD; end
                    M_INVALID: state_d = S_FAULT;
                    default: begin
                        if (timer_q == '0) begin
                            state_d = S_DOSE_HOLD;
                            done_d  = 1'b1;
                        end else begin
                            timer_d = timer_q - 8'd1;
                        end
                    end
                endcase
            end
            S_DRAIN: begin
                case (mode_c)
                    M_IDLE:    state_d = S_IDLE;
                    M_DOSE:    begin state_d = S_DOSE; timer_d = DOSE_LOAD; end
                    M_INVALID: state_d = S_FAULT;
                    default: begin
                        if (timer_q == '0 || tank_empty) begin
                            state_d = S_DRAIN_HOLD;
                            done_d  = 1'b1;
                        end else begin
                            timer_d = timer_q - 8'd1;
                        end
                    end
                endcase
            end
            S_DOSE_HOLD: begin
                case (mode_c)
                    M_IDLE:    state_d = S_IDLE;
                    M_CLEAN:   begin state_d = S_DRAIN; timer_d = DRAIN_LOAD; end
                    M_INVALID: state_d = S_FAULT;
                    default:   state_d = S_DOSE_HOLD;
                endcase
            end
            S_DRAIN_HOLD: begin
                case (mode_c)
                    M_IDLE:    state_d = S_IDLE;
                    M_DOSE:    begin state_d = S_DOSE; timer_d = DOSE_LOAD; end
                    M_INVALID: state_d = S_FAULT;
                    default:   state_d = S_DRAIN_HOLD;
                endcase
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode from the registered state.
    always_comb begin
        dose_valve  = (state_q == S_DOSE);
        drain_valve = (state_q == S_DRAIN);
        pump        = (state_q == S_DRAIN);
        busy        = (state_q == S_DOSE) || (state_q == S_DRAIN);
        fault       = (state_q == S_FAULT);
        done        = done_q;
    end

`ifdef LIMP_ACT_COUNT_EN
    logic [7:0] count_q;

    // Saturating count of completed operations, stepping together with done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (done_d && count_q != '1) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign run_count = count_q;
`else
    assign run_count = '0;
`endif

endmodule

// File: tb/tb_limp_actuator.sv
// Directed self-checking bench for limp_actuator (DOSE_CYCLES=4, DRAIN_CYCLES=6).
module tb_limp_actuator;

    logic       clock;
    logic       reset;
    logic [1:0] mode;
    logic       tank_empty;
    logic       dose_valve, drain_valve, pump, busy, done, fault;
    logic [7:0] run_count;

    int unsigned checks;
    int unsigned errors;
    int unsigned exp_cnt;

    limp_actuator #(
        .DOSE_CYCLES (4),
        .DRAIN_CYCLES(6)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mode       (mode),
        .tank_empty (tank_empty),
        .dose_valve (dose_valve),
        .drain_valve(drain_valve),
        .pump       (pump),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .run_count  (run_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Outputs packed as {dose, drain, pump, busy, done, fault}.
    task automatic check_out(input string tag, input logic [5:0] expv);
        logic [5:0] obs;
        obs = {dose_valve, drain_valve, pump, busy, done, fault};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_cnt(input string tag);
        logic [7:0] expv;
`ifdef LIMP_ACT_COUNT_EN
        expv = (exp_cnt > 255) ? 8'd255 : 8'(exp_cnt);
`else
        expv = 8'd0;
`endif
        checks++;
        assert (run_count === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, run_count, expv);
        end
    endtask

    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_DOSE  = 6'b100100;
    localparam logic [5:0] O_DRAIN = 6'b011100;
    localparam logic [5:0] O_DONE  = 6'b000010;
    localparam logic [5:0] O_FAULT = 6'b000001;

    initial begin
        checks     = 0;
        errors     = 0;
        exp_cnt    = 0;
        reset      = 1'b0;
        mode       = 2'b01;
        tank_empty = 1'b0;

        // Reset held: everything quiet even with mode requesting a dose.
        #2;
        check_out("reset_async", O_IDLE);
        check_cnt("reset_cnt");
        step();
        step();
        check_out("reset_clocked", O_IDLE);
        mode  = 2'b00;
        reset = 1'b1;
        step();
        check_out("idle_after_reset", O_IDLE);

        // Full dose: 4 clocks open, one done pulse, hold, then idle.
        mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out($sformatf("dose_cycle%0d", i + 1), O_DOSE);
        end
        step();
        exp_cnt++;
        check_out("dose_done", O_DONE);
        check_cnt("dose_done_cnt");
        step();
        check_out("dose_hold", O_IDLE);
        mode = 2'b00;
        step();
        check_out("dose_to_idle", O_IDLE);

        // Drain cut short by tank_empty sampled in the 3rd cycle.
        mode = 2'b10;
        step();
        check_out("drain_c1", O_DRAIN);
        step();
        check_out("drain_c2", O_DRAIN);
        step();
        check_out("drain_c3", O_DRAIN);
        tank_empty = 1'b1;
        step();
        exp_cnt++;
        check_out("drain_empty_done", O_DONE);
        check_cnt("drain_empty_cnt");
        tank_empty = 1'b0;
        mode = 2'b00;
        step();
        check_out("drain_to_idle", O_IDLE);

        // Abort in dose cycle 2; tank_empty must not affect dosing.
        mode = 2'b01;
        tank_empty = 1'b1;
        step();
        check_out("abort_c1", O_DOSE);
        step();
        check_out("abort_c2_tank_ignored", O_DOSE);
        mode = 2'b00;
        step();
        check_out("abort_idle_no_done", O_IDLE);
        check_cnt("abort_cnt");
        tank_empty = 1'b0;

        // Dose then drain straight from DOSE_HOLD; drain runs to timeout.
        mode = 2'b01;
        for (int i = 0; i < 4; i++) step();
        check_out("chain_dose_c4", O_DOSE);
        step();
        exp_cnt++;
        check_out("chain_dose_done", O_DONE);
        mode = 2'b10;
        for (int i = 0; i < 6; i++) begin
            step();
            check_out($sformatf("chain_drain_c%0d", i + 1), O_DRAIN);
        end
        step();
        exp_cnt++;
        check_out("chain_drain_done", O_DONE);
        check_cnt("chain_cnt");
        mode = 2'b00;
        step();
        check_out("chain_idle", O_IDLE);

        // Switch dose->drain mid-run, then invalid mode faults.
        mode = 2'b01;
        step();
        check_out("switch_dose", O_DOSE);
        mode = 2'b10;
        step();
        check_out("switch_drain", O_DRAIN);
        mode = 2'b11;
        step();
        check_out("fault_entry", O_FAULT);
        mode = 2'b00;
        step();
        step();
        step();
        check_out("fault_sticky", O_FAULT);
        reset = 1'b0;
        exp_cnt = 0;
        #1;
        check_out("fault_cleared", O_IDLE);
        check_cnt("fault_reset_cnt");
        step();
        reset = 1'b1;

        // Abort beats tank_empty in the same drain cycle: no done.
        mode = 2'b10;
        step();
        check_out("prio_drain", O_DRAIN);
        mode = 2'b00;
        tank_empty = 1'b1;
        step();
        check_out("prio_abort", O_IDLE);
        tank_empty = 1'b0;

        // Reset mid-drain between edges closes valves immediately.
        mode = 2'b10;
        step();
        step();
        check_out("mid_drain", O_DRAIN);
        #2;
        reset = 1'b0;
        #1;
        check_out("async_close", O_IDLE);
        check_cnt("async_cnt");
        mode = 2'b01;
        step();
        reset = 1'b1;
        step();
        check_out("first_edge_from_idle", O_DOSE);
        mode = 2'b00;
        step();
        check_out("back_idle", O_IDLE);

        // Count saturation: 256 more completed doses.
        for (int op = 0; op < 256; op++) begin
            mode = 2'b01;
            for (int k = 0; k < 5; k++) step();
            exp_cnt++;
            mode = 2'b00;
            step();
        end
        check_cnt("count_saturate");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
